// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between the fetch queue, the I-cache, the backend redirect source and decode.
// The master modport is the fetch queue's view; the slave modport is the surrounding environment's view.
interface inst_fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        to_icache_req_valid;
  logic [31:0] to_icache_req_addr;
  logic        from_icache_req_ready;
  logic        from_icache_rsp_valid;
  logic [31:0] from_icache_rsp_data;
  logic        to_icache_rsp_ready;
  logic        to_cpu_inst_valid;
  logic [31:0] to_cpu_inst_data;
  logic [31:0] to_cpu_inst_pc;
  logic        from_cpu_inst_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    input  from_icache_req_ready, from_icache_rsp_valid, from_icache_rsp_data,
    input  from_cpu_inst_ready,
    output to_icache_req_valid, to_icache_req_addr, to_icache_rsp_ready,
    output to_cpu_inst_valid, to_cpu_inst_data, to_cpu_inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output from_icache_req_ready, from_icache_rsp_valid, from_icache_rsp_data,
    output from_cpu_inst_ready,
    input  to_icache_req_valid, to_icache_req_addr, to_icache_rsp_ready,
    input  to_cpu_inst_valid, to_cpu_inst_data, to_cpu_inst_pc
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues one blocking I-cache request at a time and queues
// PC-tagged instructions for decode; a redirect flushes the queue and drops any in-flight response.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_queue_if.master bus_io
);
  localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DROP} state_e;

  state_e        state_q;
  logic [31:0]   reqPc_q;
  logic [31:0]   nextPc_q;
  logic          dropFlag_q;
  logic          reqValid_q;
  logic          rspReady_q;
  logic [31:0]   dataMem_q [DEPTH];
  logic [31:0]   pcMem_q [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;

  logic        redirect;
  logic [31:0] redirectPc;
  logic        reqFire;
  logic        rspFire;
  logic        push;
  logic        pop;

  assign redirect   = bus_io.redirect_valid;
  assign redirectPc = bus_io.redirect_pc & 32'hFFFF_FFFC;
  assign reqFire    = reqValid_q & bus_io.from_icache_req_ready;
  assign rspFire    = rspReady_q & bus_io.from_icache_rsp_valid;
  assign push       = rspFire && (state_q == WAIT_RSP) && !redirect;
  assign pop        = (count_q != '0) && bus_io.from_cpu_inst_ready;

  // A redirect wins over push and pop; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (redirect) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PW'(1);
      if (pop)  rdPtr_d = rdPtr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        dataMem_q[i] <= '0;
        pcMem_q[i]   <= '0;
      end
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      if (push) begin
        dataMem_q[wrPtr_q] <= bus_io.from_icache_rsp_data;
        pcMem_q[wrPtr_q]   <= reqPc_q;
      end
    end
  end

  // Once a request is redirected away, its eventual response must still be drained in DROP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      reqPc_q    <= RESET_PC;
      nextPc_q   <= RESET_PC;
      dropFlag_q <= 1'b0;
      reqValid_q <= 1'b0;
      rspReady_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            nextPc_q <= redirectPc;
          end else if (count_q < FULL) begin
            reqPc_q    <= nextPc_q;
            reqValid_q <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (redirect) begin
            nextPc_q   <= redirectPc;
            dropFlag_q <= 1'b1;
          end
          if (reqFire) begin
            reqValid_q <= 1'b0;
            rspReady_q <= 1'b1;
            if (redirect || dropFlag_q) begin
              state_q <= DROP;
            end else begin
              nextPc_q <= reqPc_q + 32'd4;
              state_q  <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (redirect) begin
            nextPc_q <= redirectPc;
            if (rspFire) begin
              rspReady_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              dropFlag_q <= 1'b1;
              state_q    <= DROP;
            end
          end else if (rspFire) begin
            rspReady_q <= 1'b0;
            if (count_d < FULL) begin
              reqPc_q    <= nextPc_q;
              reqValid_q <= 1'b1;
              state_q    <= REQ;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DROP: begin
          if (redirect) nextPc_q <= redirectPc;
          if (rspFire) begin
            dropFlag_q <= 1'b0;
            rspReady_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.to_icache_req_valid = reqValid_q;
  assign bus_io.to_icache_req_addr  = reqPc_q;
  assign bus_io.to_icache_rsp_ready = rspReady_q;
  assign bus_io.to_cpu_inst_valid   = (count_q != '0);
  assign bus_io.to_cpu_inst_data    = dataMem_q[rdPtr_q];
  assign bus_io.to_cpu_inst_pc      = pcMem_q[rdPtr_q];
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: one instance at RESET_PC 0, one at 0xFFFF_FFFC for the wrap case.
// Inputs change 1ns after the rising edge and outputs are checked at that same point.
module tb_inst_fetch_queue;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  inst_fetch_queue_if ifA ();
  inst_fetch_queue_if ifB ();

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dutA (
    .clk(clk), .rst(rst), .bus_io(ifA)
  );
  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dutB (
    .clk(clk), .rst(rst), .bus_io(ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cpuReady);
    ifA.redirect_valid        = 1'b0;
    ifA.redirect_pc           = '0;
    ifA.from_icache_req_ready = 1'b0;
    ifA.from_icache_rsp_valid = 1'b0;
    ifA.from_icache_rsp_data  = '0;
    ifA.from_cpu_inst_ready   = cpuReady;
  endtask

  task automatic doReset(input logic cpuReady);
    rst = 1'b1;
    applyStimulus(cpuReady);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic handshakeReq(input logic [31:0] expAddr);
    int n = 0;
    while (!ifA.to_icache_req_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("reqValidWait", {31'b0, ifA.to_icache_req_valid}, 32'd1);
    checkOutput("reqAddr", ifA.to_icache_req_addr, expAddr);
    ifA.from_icache_req_ready = 1'b1;
    tick();
    ifA.from_icache_req_ready = 1'b0;
    checkOutput("rspReadyAfterReq", {31'b0, ifA.to_icache_rsp_ready}, 32'd1);
  endtask

  task automatic serve(input logic [31:0] expAddr, input logic [31:0] data);
    handshakeReq(expAddr);
    ifA.from_icache_rsp_valid = 1'b1;
    ifA.from_icache_rsp_data  = data;
    tick();
    ifA.from_icache_rsp_valid = 1'b0;
  endtask

  task automatic checkHead(input logic [31:0] expPc, input logic [31:0] expData);
    checkOutput("instValid", {31'b0, ifA.to_cpu_inst_valid}, 32'd1);
    checkOutput("instPc", ifA.to_cpu_inst_pc, expPc);
    checkOutput("instData", ifA.to_cpu_inst_data, expData);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    applyStimulus(1'b1);
    ifB.redirect_valid        = 1'b0;
    ifB.redirect_pc           = '0;
    ifB.from_icache_req_ready = 1'b0;
    ifB.from_icache_rsp_valid = 1'b0;
    ifB.from_icache_rsp_data  = '0;
    ifB.from_cpu_inst_ready   = 1'b1;
    tick();
    tick();

    checkOutput("rstReqValid", {31'b0, ifA.to_icache_req_valid}, 32'd0);
    checkOutput("rstReqAddr", ifA.to_icache_req_addr, 32'h0);
    checkOutput("rstRspReady", {31'b0, ifA.to_icache_rsp_ready}, 32'd0);
    checkOutput("rstInstValid", {31'b0, ifA.to_cpu_inst_valid}, 32'd0);
    checkOutput("rstInstData", ifA.to_cpu_inst_data, 32'h0);
    checkOutput("rstInstPc", ifA.to_cpu_inst_pc, 32'h0);
    checkOutput("rstReqAddrB", ifB.to_icache_req_addr, 32'hFFFF_FFFC);

    // Sequential fetch with an always-hitting cache and an always-ready decode
    rst = 1'b0;
    checkOutput("firstCycleIdle", {31'b0, ifA.to_icache_req_valid}, 32'd0);
    tick();
    checkOutput("secondCycleReq", {31'b0, ifA.to_icache_req_valid}, 32'd1);
    serve(32'h0, 32'hA000_0000);
    checkHead(32'h0, 32'hA000_0000);
    serve(32'h4, 32'hA000_0004);
    checkHead(32'h4, 32'hA000_0004);
    serve(32'h8, 32'hA000_0008);
    checkHead(32'h8, 32'hA000_0008);
    tick();
    checkOutput("drainedEmpty", {31'b0, ifA.to_cpu_inst_valid}, 32'd0);

    // Fill to DEPTH with decode stalled, then one pop frees a slot for 0x10
    doReset(1'b0);
    serve(32'h0, 32'hB000_0000);
    serve(32'h4, 32'hB000_0004);
    serve(32'h8, 32'hB000_0008);
    serve(32'hC, 32'hB000_000C);
    checkHead(32'h0, 32'hB000_0000);
    for (int i = 0; i < 3; i++) begin
      checkOutput("fullNoReq", {31'b0, ifA.to_icache_req_valid}, 32'd0);
      tick();
    end
    ifA.from_cpu_inst_ready = 1'b1;
    tick();
    ifA.from_cpu_inst_ready = 1'b0;
    checkHead(32'h4, 32'hB000_0004);
    checkOutput("stillIdleAfterPop", {31'b0, ifA.to_icache_req_valid}, 32'd0);
    tick();
    checkOutput("reqAfterPop", {31'b0, ifA.to_icache_req_valid}, 32'd1);
    serve(32'h10, 32'hB000_0010);
    ifA.from_cpu_inst_ready = 1'b1;
    checkHead(32'h4, 32'hB000_0004);
    tick();
    checkHead(32'h8, 32'hB000_0008);
    tick();
    checkHead(32'hC, 32'hB000_000C);
    tick();
    checkHead(32'h10, 32'hB000_0010);
    tick();
    checkOutput("wrapDrained", {31'b0, ifA.to_cpu_inst_valid}, 32'd0);

    // Redirect while waiting for the 0x8 response
    doReset(1'b0);
    serve(32'h0, 32'hC000_0000);
    serve(32'h4, 32'hC000_0004);
    handshakeReq(32'h8);
    ifA.redirect_valid = 1'b1;
    ifA.redirect_pc    = 32'h1000;
    tick();
    ifA.redirect_valid = 1'b0;
    checkOutput("flushEmpty", {31'b0, ifA.to_cpu_inst_valid}, 32'd0);
    checkOutput("dropRspReady", {31'b0, ifA.to_icache_rsp_ready}, 32'd1);
    checkOutput("dropNoReq", {31'b0, ifA.to_icache_req_valid}, 32'd0);
    ifA.from_icache_rsp_valid = 1'b1;
    ifA.from_icache_rsp_data  = 32'hDEAD_0008;
    tick();
    ifA.from_icache_rsp_valid = 1'b0;
    checkOutput("droppedNoPush", {31'b0, ifA.to_cpu_inst_valid}, 32'd0);
    checkOutput("dropDoneRspReady", {31'b0, ifA.to_icache_rsp_ready}, 32'd0);
    serve(32'h1000, 32'hC000_1000);
    checkHead(32'h1000, 32'hC000_1000);

    // Stalled request with redirect on its second stall cycle
    doReset(1'b1);
    serve(32'h0, 32'hD000_0000);
    serve(32'h4, 32'hD000_0004);
    for (int i = 0; i < 5; i++) begin
      ifA.redirect_valid = (i == 1);
      ifA.redirect_pc    = 32'h2000;
      tick();
      ifA.redirect_valid = 1'b0;
      checkOutput("stallReqValid", {31'b0, ifA.to_icache_req_valid}, 32'd1);
      checkOutput("stallReqAddr", ifA.to_icache_req_addr, 32'h8);
    end
    ifA.from_icache_req_ready = 1'b1;
    tick();
    ifA.from_icache_req_ready = 1'b0;
    checkOutput("stallDropRspReady", {31'b0, ifA.to_icache_rsp_ready}, 32'd1);
    checkOutput("stallDropNoReq", {31'b0, ifA.to_icache_req_valid}, 32'd0);
    ifA.from_icache_rsp_valid = 1'b1;
    ifA.from_icache_rsp_data  = 32'hDEAD_0808;
    tick();
    ifA.from_icache_rsp_valid = 1'b0;
    checkOutput("stallDropNoPush", {31'b0, ifA.to_cpu_inst_valid}, 32'd0);
    tick();
    checkOutput("stallNewReq", {31'b0, ifA.to_icache_req_valid}, 32'd1);
    checkOutput("stallNewAddr", ifA.to_icache_req_addr, 32'h2000);

    // Redirect coinciding with the response handshake, unaligned target
    doReset(1'b0);
    serve(32'h0, 32'hE000_0000);
    handshakeReq(32'h4);
    ifA.from_icache_rsp_valid = 1'b1;
    ifA.from_icache_rsp_data  = 32'hDEAD_0004;
    ifA.redirect_valid        = 1'b1;
    ifA.redirect_pc           = 32'h3003;
    tick();
    ifA.from_icache_rsp_valid = 1'b0;
    ifA.redirect_valid        = 1'b0;
    checkOutput("sameCycleNoPush", {31'b0, ifA.to_cpu_inst_valid}, 32'd0);
    checkOutput("sameCycleRspReady", {31'b0, ifA.to_icache_rsp_ready}, 32'd0);
    checkOutput("sameCycleIdle", {31'b0, ifA.to_icache_req_valid}, 32'd0);
    tick();
    checkOutput("alignedReqValid", {31'b0, ifA.to_icache_req_valid}, 32'd1);
    checkOutput("alignedReqAddr", ifA.to_icache_req_addr, 32'h3000);

    // Address wrap on the instance starting at 0xFFFF_FFFC
    doReset(1'b1);
    tick();
    checkOutput("wrapFirstValid", {31'b0, ifB.to_icache_req_valid}, 32'd1);
    checkOutput("wrapFirstAddr", ifB.to_icache_req_addr, 32'hFFFF_FFFC);
    ifB.from_icache_req_ready = 1'b1;
    tick();
    ifB.from_icache_req_ready = 1'b0;
    checkOutput("wrapRspReady", {31'b0, ifB.to_icache_rsp_ready}, 32'd1);
    ifB.from_icache_rsp_valid = 1'b1;
    ifB.from_icache_rsp_data  = 32'hF00D_FFFC;
    tick();
    ifB.from_icache_rsp_valid = 1'b0;
    checkOutput("wrapSecondValid", {31'b0, ifB.to_icache_req_valid}, 32'd1);
    checkOutput("wrapSecondAddr", ifB.to_icache_req_addr, 32'h0);
    checkOutput("wrapHeadPc", ifB.to_cpu_inst_pc, 32'hFFFF_FFFC);
    checkOutput("wrapHeadData", ifB.to_cpu_inst_data, 32'hF00D_FFFC);

    // Asynchronous reset while a response is outstanding
    doReset(1'b0);
    serve(32'h0, 32'h1234_5678);
    handshakeReq(32'h4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncReqValid", {31'b0, ifA.to_icache_req_valid}, 32'd0);
    checkOutput("asyncReqAddr", ifA.to_icache_req_addr, 32'h0);
    checkOutput("asyncRspReady", {31'b0, ifA.to_icache_rsp_ready}, 32'd0);
    checkOutput("asyncInstValid", {31'b0, ifA.to_cpu_inst_valid}, 32'd0);
    checkOutput("asyncInstData", ifA.to_cpu_inst_data, 32'h0);
    checkOutput("asyncInstPc", ifA.to_cpu_inst_pc, 32'h0);
    tick();
    rst = 1'b0;
    checkOutput("restartIdle", {31'b0, ifA.to_icache_req_valid}, 32'd0);
    tick();
    checkOutput("restartReqValid", {31'b0, ifA.to_icache_req_valid}, 32'd1);
    checkOutput("restartReqAddr", ifA.to_icache_req_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
